// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-triggered 8-line priority interrupt controller
// Build macro IRQ_SYNC_EN inserts a two-flop synchronizer ahead of edge detection.
module interrupt_controller (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] irq_in,
  input  logic [7:0] z_bus,
  input  logic       ctrl_irq_masks_wrt,
  input  logic       ctrl_int_ack,
  input  logic       ctrl_clear_all_ints,
  output logic       int_pending,
  output logic [7:0] int_vector,
  output logic [7:0] irq_status,
  output logic [7:0] irq_masks
);

  logic [7:0] sampled;
  logic [7:0] prev;
  logic [7:0] pending;
  logic [7:0] masked;
  logic [7:0] rise;
  logic [7:0] ack_clear;
  logic [2:0] win_idx;
  logic       ack_eff;

`ifdef IRQ_SYNC_EN
  logic [7:0] sync_1;
  logic [7:0] sync_2;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq_in;
      sync_2 <= sync_1;
    end
  end

  assign sampled = sync_2;
`else
  assign sampled = irq_in;
`endif

  assign rise        = sampled & ~prev;
  assign masked      = pending & irq_masks;
  assign int_pending = |masked;
  assign irq_status  = pending;

  // Lowest enabled index wins; scan downward so the last hit is the smallest.
  always_comb begin
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (masked[i]) win_idx = 3'(i);
    end
  end

  // Clear-all suppresses the acknowledge entirely, so the vector keeps its value.
  assign ack_eff   = ctrl_int_ack & int_pending & ~ctrl_clear_all_ints;
  assign ack_clear = ack_eff ? (8'b0000_0001 << win_idx) : 8'h00;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      prev       <= '0;
      pending    <= '0;
      irq_masks  <= '0;
      int_vector <= '0;
    end else begin
      prev <= sampled;
      if (ctrl_irq_masks_wrt) irq_masks <= z_bus;
      // A new edge is OR-ed in after the ack clear so a same-cycle request survives.
      if (ctrl_clear_all_ints) pending <= '0;
      else                     pending <= (pending & ~ack_clear) | rise;
      if (ack_eff) int_vector <= {4'b0000, win_idx, 1'b0};
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized and directed bench for interrupt_controller
// Reference model tracks pending/mask/vector as plain bit sets with a delay line for sync.
module tb_interrupt_controller;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] irq_in = '0;
  logic [7:0] z_bus = '0;
  logic       ctrl_irq_masks_wrt = 1'b0;
  logic       ctrl_int_ack = 1'b0;
  logic       ctrl_clear_all_ints = 1'b0;
  logic       int_pending;
  logic [7:0] int_vector;
  logic [7:0] irq_status;
  logic [7:0] irq_masks;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_pend = '0, m_mask = '0, m_vec = '0, m_prev = '0, d0 = '0, d1 = '0;

  interrupt_controller dut (
    .clk(clk), .arst(arst), .irq_in(irq_in), .z_bus(z_bus),
    .ctrl_irq_masks_wrt(ctrl_irq_masks_wrt), .ctrl_int_ack(ctrl_int_ack),
    .ctrl_clear_all_ints(ctrl_clear_all_ints), .int_pending(int_pending),
    .int_vector(int_vector), .irq_status(irq_status), .irq_masks(irq_masks)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the current inputs, then the DUT.
  task automatic tick();
    logic [7:0] seen, eff, nxt;
    int win;
    if (arst) begin
      m_pend = '0; m_mask = '0; m_vec = '0; m_prev = '0; d0 = '0; d1 = '0;
    end else begin
      seen = (LAT == 0) ? irq_in : d1;
      eff  = m_pend & m_mask;
      win  = -1;
      for (int i = 7; i >= 0; i--) if (eff[i]) win = i;
      nxt = m_pend;
      if (ctrl_clear_all_ints) nxt = '0;
      else begin
        if (ctrl_int_ack && win >= 0) begin
          nxt[win] = 1'b0;
          m_vec = 8'(win * 2);
        end
        nxt = nxt | (seen & ~m_prev);
      end
      m_pend = nxt;
      if (ctrl_irq_masks_wrt) m_mask = z_bus;
      m_prev = seen;
      d1 = d0;
      d0 = irq_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({int_pending, int_vector, irq_status, irq_masks} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got pend=%b vec=%h st=%h mk=%h want all 0", int_pending, int_vector, irq_status, irq_masks);
    end
    arst = 1'b0;
    tick();
  endtask

  task automatic test_pulse();
    ctrl_irq_masks_wrt = 1'b1; z_bus = 8'hFF;
    tick();
    ctrl_irq_masks_wrt = 1'b0;
    vectors++;
    if (irq_masks !== 8'hFF) begin
      miscompares++;
      $display("FAIL mask_write got %h want ff", irq_masks);
    end
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    vectors++;
    if (irq_status !== 8'h08 || int_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL pulse_bit3 got st=%h pend=%b want st=08 pend=1", irq_status, int_pending);
    end
    ctrl_clear_all_ints = 1'b1;
    tick();
    ctrl_clear_all_ints = 1'b0;
    vectors++;
    if (irq_status !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_after_pulse got %h want 00", irq_status);
    end
  endtask

  task automatic test_ack_priority();
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    vectors++;
    if (irq_status !== 8'h24) begin
      miscompares++;
      $display("FAIL prio_setup got %h want 24", irq_status);
    end
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_int_ack = 1'b0;
    vectors++;
    if (int_vector !== 8'h04 || irq_status !== 8'h20 || int_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_ack1 got vec=%h st=%h pend=%b want 04 20 1", int_vector, irq_status, int_pending);
    end
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_int_ack = 1'b0;
    vectors++;
    if (int_vector !== 8'h0A || irq_status !== 8'h00 || int_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_ack2 got vec=%h st=%h pend=%b want 0a 00 0", int_vector, irq_status, int_pending);
    end
  endtask

  task automatic test_mask();
    ctrl_irq_masks_wrt = 1'b1; z_bus = 8'h00;
    tick();
    ctrl_irq_masks_wrt = 1'b0;
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    vectors++;
    if (irq_status !== 8'h01 || int_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL masked_pending got st=%h pend=%b want 01 0", irq_status, int_pending);
    end
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_int_ack = 1'b0;
    vectors++;
    if (irq_status !== 8'h01 || int_vector !== 8'h0A) begin
      miscompares++;
      $display("FAIL idle_ack got st=%h vec=%h want 01 0a", irq_status, int_vector);
    end
    ctrl_irq_masks_wrt = 1'b1; z_bus = 8'h01;
    tick();
    ctrl_irq_masks_wrt = 1'b0;
    vectors++;
    if (int_pending !== 1'b1 || irq_status !== 8'h01) begin
      miscompares++;
      $display("FAIL unmask_pending got pend=%b st=%h want 1 01", int_pending, irq_status);
    end
    ctrl_clear_all_ints = 1'b1; ctrl_irq_masks_wrt = 1'b1; z_bus = 8'hFF;
    tick();
    ctrl_clear_all_ints = 1'b0; ctrl_irq_masks_wrt = 1'b0;
  endtask

  task automatic test_same_cycle_ack();
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    tick();
    irq_in = 8'h02;
    repeat (LAT) tick();
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_int_ack = 1'b0;
    irq_in = 8'h00;
    vectors++;
    if (irq_status[1] !== 1'b1 || int_vector !== 8'h02) begin
      miscompares++;
      $display("FAIL same_cycle_ack got st=%h vec=%h want st[1]=1 vec=02", irq_status, int_vector);
    end
    ctrl_clear_all_ints = 1'b1;
    tick();
    ctrl_clear_all_ints = 1'b0;
  endtask

  task automatic test_clear_all();
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    irq_in = 8'h80;
    repeat (LAT) tick();
    ctrl_clear_all_ints = 1'b1; ctrl_int_ack = 1'b1;
    tick();
    ctrl_clear_all_ints = 1'b0; ctrl_int_ack = 1'b0;
    vectors++;
    if (irq_status !== 8'h00 || int_vector !== 8'h02) begin
      miscompares++;
      $display("FAIL clear_dominates got st=%h vec=%h want 00 02", irq_status, int_vector);
    end
    repeat (LAT + 1) tick();
    irq_in = 8'h00;
    vectors++;
    if (irq_status !== 8'h00) begin
      miscompares++;
      $display("FAIL held_no_rerequest got %h want 00", irq_status);
    end
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h04;
    repeat (LAT + 1) tick();
    ctrl_int_ack = 1'b1;
    #2;
    arst = 1'b1;
    #1;
    vectors++;
    if ({int_pending, int_vector, irq_status, irq_masks} !== 25'd0) begin
      miscompares++;
      $display("FAIL async_reset got pend=%b vec=%h st=%h mk=%h want all 0", int_pending, int_vector, irq_status, irq_masks);
    end
    repeat (2) tick();
    arst = 1'b0;
    ctrl_int_ack = 1'b0;
    repeat (LAT) tick();
    vectors++;
    if (irq_status !== 8'h00) begin
      miscompares++;
      $display("FAIL pre_sample got %h want 00", irq_status);
    end
    tick();
    vectors++;
    if (irq_status !== 8'h04 || irq_masks !== 8'h00 || int_pending !== 1'b0 || int_vector !== 8'h00) begin
      miscompares++;
      $display("FAIL post_reset got st=%h mk=%h pend=%b vec=%h want 04 00 0 00", irq_status, irq_masks, int_pending, int_vector);
    end
    repeat (3) tick();
    irq_in = 8'h00;
    vectors++;
    if (irq_status !== 8'h04) begin
      miscompares++;
      $display("FAIL one_request got %h want 04", irq_status);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      irq_in              = irq_in ^ (8'($urandom) & 8'($urandom));
      ctrl_int_ack        = 1'($urandom_range(0, 1));
      ctrl_clear_all_ints = ($urandom_range(0, 15) == 0);
      ctrl_irq_masks_wrt  = ($urandom_range(0, 7) == 0);
      z_bus               = 8'($urandom);
      arst                = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if (irq_status !== m_pend || irq_masks !== m_mask || int_vector !== m_vec ||
          int_pending !== ((m_pend & m_mask) != 8'h00)) begin
        miscompares++;
        $display("FAIL random[%0d] got st=%h mk=%h vec=%h pend=%b want st=%h mk=%h vec=%h pend=%b",
                 n, irq_status, irq_masks, int_vector, int_pending,
                 m_pend, m_mask, m_vec, (m_pend & m_mask) != 8'h00);
      end
    end
    arst = 1'b0; ctrl_int_ack = 1'b0; ctrl_clear_all_ints = 1'b0; ctrl_irq_masks_wrt = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_ack_priority();
    test_mask();
    test_same_cycle_ack();
    test_clear_all();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL use reset arst, asynchronous, active-high, and clock clk.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  system clock; all state updates on the rising edge.
- arst  in  1  asynchronous active-high reset.
- irq_in  in  8  raw interrupt request lines; a rising edge requests service.
- z_bus  in  8  data source for mask register writes.
- ctrl_irq_masks_wrt  in  1  active-high; loads the mask register from z_bus.
- ctrl_int_ack  in  1  active-high single-cycle acknowledge from the microcode sequencer.
- ctrl_clear_all_ints  in  1  active-high; discards all pending requests.
- int_pending  out  1  at least one enabled request is pending.
- int_vector  out  8  vector of the last acknowledged request.
- irq_status  out  8  raw pending bits, masked and unmasked.
- irq_masks  out  8  current mask register; 1 = enabled.

Function
REQ-003 Edge detect: the block SHALL keep a per-line previous-sample register; pending[i] SHALL set on a clk edge where the sampled line is 1 and its previous sample is 0.
REQ-004 Pending bits SHALL be sticky and SHALL be cleared only by acknowledge, clear-all or reset; a level held high SHALL NOT re-request.
REQ-005 int_pending SHALL be combinational and equal to OR(pending & masks).
REQ-006 Masked requests SHALL remain pending; int_pending SHALL assert in the cycle after a mask write enables them.
REQ-007 Priority: the lowest index among (pending & masks) SHALL win.
REQ-008 On a clk edge with ctrl_int_ack=1 and int_pending=1, the block SHALL:
- clear the winning pending bit;
- register int_vector = {4'b0000, idx[2:0], 1'b0}, where idx is the winner's index.
REQ-009 int_vector SHALL hold its value until the next effective acknowledge.
REQ-010 ctrl_int_ack with int_pending=0 SHALL change no state.
REQ-011 Acknowledge SHALL evaluate the pre-edge mask; a simultaneous mask write takes effect from the next cycle.
REQ-012 A new edge on the same line in the same cycle its bit is acknowledged SHALL leave that bit set, so no request is lost.
REQ-013 ctrl_clear_all_ints SHALL clear all pending bits and SHALL dominate both a simultaneous acknowledge and new edges in that cycle. The previous-sample register still updates; int_vector is unchanged.
REQ-014 Mask write: irq_masks SHALL equal z_bus after the edge on which ctrl_irq_masks_wrt=1; the write SHALL NOT affect pending bits.
REQ-015 irq_status SHALL equal the pending register directly.

Reset
REQ-016 While arst=1, the following SHALL be 0x00 immediately, independent of clk: pending, masks, previous-sample, synchronizer flops, and int_vector. int_pending SHALL be 0 during the same interval.
REQ-017 Because the previous-sample register resets to 0, a line held high across reset release SHALL latch exactly one request at the first sampling edge.
REQ-018 Reset asserted mid-acknowledge SHALL abort that acknowledge; no partial update SHALL survive.

Configuration
REQ-019 Macro IRQ_SYNC_EN SHALL control input synchronization:
- Defined: each irq_in line passes through a two-flop synchronizer before edge detection; an irq_in rise before edge N sets pending at edge N+2.
- Undefined: irq_in feeds edge detection directly; pending sets at edge N.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover:
- Mask write 0xFF, then pulse irq_in[3] high for 1 cycle -> irq_status=0x08, int_pending=1. Pending sets at edge N, or N+2 with IRQ_SYNC_EN.
- Set pending 0x24 with masks 0xFF, then ack twice -> int_vector 0x04 then 0x0A; irq_status goes 0x20 then 0x00; int_pending falls after the second ack.
- Masks 0x00, edge on irq_in[0] -> irq_status=0x01, int_pending=0. Then write masks 0x01 -> int_pending=1 the next cycle.
- Ack of bit 1 in the same cycle as a new edge on irq_in[1] -> irq_status[1]=1 afterwards and int_vector=0x02.
- ctrl_clear_all_ints with ack and an edge on irq_in[7] in the same cycle -> irq_status=0x00 and int_vector unchanged.
- arst pulse mid-sequence with irq_in[2] held high -> all outputs 0 during reset, then irq_status=0x04 after the first sampling edge (masks still 0x00).
